// File: rtl/hv_enabled_mc.sv
// ---------------------------------------------------------------------------
// hv_enabled_mc
//
// Multi-channel HV enable gate. Each channel watches its HV request line and
// holds its downstream enable low for a programmable prescaled delay after
// the request rises. A per-channel permit input bypasses the delay.
//
// Optional feature macro: HV_ENABLED_HOLDOFF_EN
//   defined   : after any HV fall from DELAY or ON the channel sits in a
//               HOLDOFF state for (holdoff+1)*(prescale+1) cycles and ignores
//               rises; if HV is high when hold-off ends a fresh DELAY starts.
//   undefined : no HOLDOFF state, the holdoff port is unused.
//
// Ports
//   clk        in   system clock, rising edge
//   sclr       in   synchronous active-high reset
//   hv         in   [CHANNELS]          per-channel HV request (raw level)
//   permit     in   [CHANNELS]          per-channel delay bypass
//   prescale   in   [PRESCALE_WIDTH]    tick period minus 1 (shared, static)
//   length     in   [CHANNELS*WIDTH]    channel i delay ticks minus 1
//   holdoff    in   [WIDTH]             hold-off ticks minus 1 (shared)
//   enabled    out  [CHANNELS]          HV enable to downstream
//   busy       out  [CHANNELS]          channel in DELAY or HOLDOFF
//   done       out  [CHANNELS]          1-cycle pulse on normal DELAY completion
//   dbg_state  out  [2*CHANNELS]        channel i FSM state at [2*i +: 2]
//                                       (0 IDLE, 1 DELAY, 2 ON, 3 HOLDOFF)
// ---------------------------------------------------------------------------
module hv_enabled_mc #(
    parameter int CHANNELS       = 4,
    parameter int PRESCALE_WIDTH = 16,
    parameter int WIDTH          = 16
) (
    input  logic                        clk,
    input  logic                        sclr,
    input  logic [CHANNELS-1:0]         hv,
    input  logic [CHANNELS-1:0]         permit,
    input  logic [PRESCALE_WIDTH-1:0]   prescale,
    input  logic [CHANNELS*WIDTH-1:0]   length,
    input  logic [WIDTH-1:0]            holdoff,
    output logic [CHANNELS-1:0]         enabled,
    output logic [CHANNELS-1:0]         busy,
    output logic [CHANNELS-1:0]         done,
    output logic [2*CHANNELS-1:0]       dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DELAY   = 2'd1,
        ST_ON      = 2'd2,
        ST_HOLDOFF = 2'd3
    } state_t;

`ifdef HV_ENABLED_HOLDOFF_EN
    localparam state_t FALL_STATE = ST_HOLDOFF;
`else
    localparam state_t FALL_STATE = ST_IDLE;
    logic w_unused_holdoff;
    assign w_unused_holdoff = ^holdoff;
`endif

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        state_t                    r_state;
        state_t                    w_next;
        logic [1:0]                r_hv_d;
        logic [PRESCALE_WIDTH-1:0] r_timer;
        logic [WIDTH-1:0]          r_cnt;
        logic [WIDTH-1:0]          r_len_q;
        logic                      r_busy;
        logic                      r_done;
        logic                      w_rise;
        logic                      w_fall;
        logic                      w_tick;
        logic                      w_term;
        logic                      w_busy_nxt;
        logic                      w_done_nxt;

        // Rise needs the previous sample low, so an hv held high through
        // reset still produces a rise once hv_d restarts from 00.
        assign w_rise = (r_hv_d == 2'b01);
        assign w_fall = ~r_hv_d[0];
        assign w_tick = (r_timer == prescale);
        assign w_term = w_tick && (r_cnt == r_len_q);

        // State register, sample register, timers and registered status.
        always_ff @(posedge clk) begin
            if (sclr) begin
                r_state <= ST_IDLE;
                r_hv_d  <= 2'b00;
                r_timer <= '0;
                r_cnt   <= '0;
                r_len_q <= '0;
                r_busy  <= 1'b0;
                r_done  <= 1'b0;
            end else begin
                r_hv_d  <= {r_hv_d[0], hv[i]};
                r_state <= w_next;
                r_busy  <= w_busy_nxt;
                r_done  <= w_done_nxt;
                if (w_next != r_state) begin
                    // Any state entry restarts the tick timer and count.
                    r_timer <= '0;
                    r_cnt   <= '0;
                    if (w_next == ST_DELAY)
                        r_len_q <= length[i*WIDTH +: WIDTH];
                end else if ((r_state == ST_DELAY) || (r_state == ST_HOLDOFF)) begin
                    if (w_tick) begin
                        r_timer <= '0;
                        r_cnt   <= r_cnt + 1'b1;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
            end
        end

        // Next state. Priority: fall > permit > terminal tick.
        always_comb begin
            w_next = r_state;
            case (r_state)
                ST_IDLE: begin
                    if (w_rise)
                        w_next = permit[i] ? ST_ON : ST_DELAY;
                end
                ST_DELAY: begin
                    if (w_fall)
                        w_next = FALL_STATE;
                    else if (permit[i] || w_term)
                        w_next = ST_ON;
                end
                ST_ON: begin
                    if (w_fall)
                        w_next = FALL_STATE;
                end
                ST_HOLDOFF: begin
`ifdef HV_ENABLED_HOLDOFF_EN
                    // Rises are ignored here; only the level at expiry matters.
                    if (w_tick && (r_cnt == holdoff))
                        w_next = r_hv_d[0] ? ST_DELAY : ST_IDLE;
`else
                    w_next = ST_IDLE;
`endif
                end
                default: w_next = ST_IDLE;
            endcase
        end

        // Output decode. done only on a terminal tick that is neither
        // overridden by a fall nor pre-empted by the permit bypass.
        always_comb begin
            w_busy_nxt = (w_next == ST_DELAY) || (w_next == ST_HOLDOFF);
            w_done_nxt = (r_state == ST_DELAY) && w_term && !w_fall && !permit[i];
        end

        // Raw hv gates the enable so it drops in the same cycle hv falls.
        assign enabled[i]          = hv[i] & (r_state == ST_ON);
        assign busy[i]             = r_busy;
        assign done[i]             = r_done;
        assign dbg_state[2*i +: 2] = r_state;
    end

endmodule
